// File: rtl/packet_parser_if.sv
// rtl/packet_parser_if.sv - character, descriptor and payload signals around the packet parser
interface packet_parser_if;
    logic       chr_drdy;
    logic [7:0] chr_data;
    logic       chr_start;
    logic       chr_end;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [6:0] cmd_addr;
    logic [7:0] cmd_len;
    logic       byte_valid;
    logic       byte_ready;
    logic [7:0] byte_data;
    logic       byte_last;
    logic       frame_err;
    logic [2:0] err_code;
    logic       busy;

    // master: the parser itself
    modport master (
        input  chr_drdy, chr_data, chr_start, chr_end, cmd_ready, byte_ready,
        output cmd_valid, cmd_write, cmd_addr, cmd_len,
        output byte_valid, byte_data, byte_last, frame_err, err_code, busy
    );

    // slave: the character decoder and register dispatcher around it
    modport slave (
        output chr_drdy, chr_data, chr_start, chr_end, cmd_ready, byte_ready,
        input  cmd_valid, cmd_write, cmd_addr, cmd_len,
        input  byte_valid, byte_data, byte_last, frame_err, err_code, busy
    );
endinterface

// File: rtl/packet_parser.sv
// rtl/packet_parser.sv - Uniboard frame assembler; optional checksum via PACKET_PARSER_CHECKSUM_EN
module packet_parser #(
    parameter int MAX_LEN = 16
) (
    input  logic            clk,
    input  logic            reset,
    packet_parser_if.master bus
);

`ifdef PACKET_PARSER_CHECKSUM_EN
    localparam int BUF_DEPTH = MAX_LEN + 1;
`else
    localparam int BUF_DEPTH = MAX_LEN;
`endif
    localparam int         IDX_W     = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam logic [8:0] LEN_LIMIT = 9'(BUF_DEPTH);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_HEADER  = 3'd1;
    localparam logic [2:0] S_PAYLOAD = 3'd2;
    localparam logic [2:0] S_CMD     = 3'd3;
    localparam logic [2:0] S_STREAM  = 3'd4;

    localparam logic [2:0] E_EMPTY        = 3'd1;
    localparam logic [2:0] E_OVERFLOW     = 3'd2;
    localparam logic [2:0] E_READ_PAYLOAD = 3'd3;
    localparam logic [2:0] E_RESYNC       = 3'd4;
    localparam logic [2:0] E_OVERRUN      = 3'd5;
    localparam logic [2:0] E_WRITE_EMPTY  = 3'd6;
`ifdef PACKET_PARSER_CHECKSUM_EN
    localparam logic [2:0] E_CHECKSUM     = 3'd7;
`endif

    logic       drdy_q;
    logic [2:0] state_q, state_d;
    logic [7:0] len_q, len_d;
    logic [7:0] idx_q, idx_d;
    logic       write_q, write_d;
    logic [6:0] addr_q, addr_d;
    logic       err_q, err_d;
    logic [2:0] code_q, code_d;
    logic       buf_we;
    logic [7:0] buf_q [0:(1 << IDX_W) - 1];
`ifdef PACKET_PARSER_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;
`endif

    logic evt, is_start, is_end, is_data, last_byte;

    // START wins if the decoder ever flags both markers at once
    assign evt       = bus.chr_drdy & ~drdy_q;
    assign is_start  = evt & bus.chr_start;
    assign is_end    = evt & ~bus.chr_start & bus.chr_end;
    assign is_data   = evt & ~bus.chr_start & ~bus.chr_end;
    assign last_byte = (idx_q == (len_q - 8'd1));

    assign bus.busy       = (state_q != S_IDLE);
    assign bus.cmd_valid  = (state_q == S_CMD);
    assign bus.cmd_write  = write_q;
    assign bus.cmd_addr   = addr_q;
    assign bus.cmd_len    = len_q;
    assign bus.byte_valid = (state_q == S_STREAM);
    assign bus.byte_data  = (state_q == S_STREAM) ? buf_q[idx_q[IDX_W-1:0]] : 8'h00;
    assign bus.byte_last  = (state_q == S_STREAM) && last_byte;
    assign bus.frame_err  = err_q;
    assign bus.err_code   = code_q;

    // frame state machine: character handling, descriptor handshake and payload streaming
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        write_d = write_q;
        addr_d  = addr_q;
        err_d   = 1'b0;
        code_d  = code_q;
        buf_we  = 1'b0;
`ifdef PACKET_PARSER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (is_start) begin
                    state_d = S_HEADER;
                    len_d   = 8'd0;
                    idx_d   = 8'd0;
`ifdef PACKET_PARSER_CHECKSUM_EN
                    csum_d  = 8'h00;
`endif
                end
            end
            S_HEADER: begin
                if (is_start) begin
                    err_d  = 1'b1;
                    code_d = E_RESYNC;
`ifdef PACKET_PARSER_CHECKSUM_EN
                    csum_d = 8'h00;
`endif
                end else if (is_end) begin
                    err_d   = 1'b1;
                    code_d  = E_EMPTY;
                    state_d = S_IDLE;
                end else if (is_data) begin
                    write_d = bus.chr_data[7];
                    addr_d  = bus.chr_data[6:0];
                    state_d = S_PAYLOAD;
`ifdef PACKET_PARSER_CHECKSUM_EN
                    csum_d  = bus.chr_data;
`endif
                end
            end
            S_PAYLOAD: begin
                if (is_start) begin
                    err_d   = 1'b1;
                    code_d  = E_RESYNC;
                    state_d = S_HEADER;
                    len_d   = 8'd0;
`ifdef PACKET_PARSER_CHECKSUM_EN
                    csum_d  = 8'h00;
`endif
                end else if (is_data) begin
                    if (write_q) begin
                        if ({1'b0, len_q} < LEN_LIMIT) begin
                            buf_we = 1'b1;
                            len_d  = len_q + 8'd1;
`ifdef PACKET_PARSER_CHECKSUM_EN
                            csum_d = csum_q ^ bus.chr_data;
`endif
                        end else begin
                            err_d   = 1'b1;
                            code_d  = E_OVERFLOW;
                            state_d = S_IDLE;
                        end
`ifdef PACKET_PARSER_CHECKSUM_EN
                    end else if (len_q == 8'd0) begin
                        // a read carries exactly one byte: its checksum
                        len_d  = 8'd1;
                        csum_d = csum_q ^ bus.chr_data;
`endif
                    end else begin
                        err_d   = 1'b1;
                        code_d  = E_READ_PAYLOAD;
                        state_d = S_IDLE;
                    end
                end else if (is_end) begin
`ifdef PACKET_PARSER_CHECKSUM_EN
                    // len_q counts the checksum byte; it is stripped on entry to CMD
                    if (write_q && len_q <= 8'd1) begin
                        err_d   = 1'b1;
                        code_d  = E_WRITE_EMPTY;
                        state_d = S_IDLE;
                    end else if (!write_q && len_q == 8'd0) begin
                        err_d   = 1'b1;
                        code_d  = E_EMPTY;
                        state_d = S_IDLE;
                    end else if (csum_q != 8'h00) begin
                        err_d   = 1'b1;
                        code_d  = E_CHECKSUM;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_CMD;
                        len_d   = write_q ? (len_q - 8'd1) : 8'd0;
                    end
`else
                    if (write_q && len_q == 8'd0) begin
                        err_d   = 1'b1;
                        code_d  = E_WRITE_EMPTY;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_CMD;
                    end
`endif
                end
            end
            S_CMD: begin
                if (evt) begin
                    err_d  = 1'b1;
                    code_d = E_OVERRUN;
                end
                if (bus.cmd_ready) begin
                    state_d = write_q ? S_STREAM : S_IDLE;
                    idx_d   = 8'd0;
                end
            end
            S_STREAM: begin
                if (evt) begin
                    err_d  = 1'b1;
                    code_d = E_OVERRUN;
                end
                if (bus.byte_ready) begin
                    idx_d = idx_q + 8'd1;
                    if (last_byte) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // control and descriptor registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drdy_q  <= 1'b0;
            state_q <= S_IDLE;
            len_q   <= 8'd0;
            idx_q   <= 8'd0;
            write_q <= 1'b0;
            addr_q  <= 7'd0;
            err_q   <= 1'b0;
            code_q  <= 3'd0;
`ifdef PACKET_PARSER_CHECKSUM_EN
            csum_q  <= 8'h00;
`endif
        end else begin
            drdy_q  <= bus.chr_drdy;
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
            code_q  <= code_d;
`ifdef PACKET_PARSER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    // payload buffer, contents are don't-care until written
    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_q[len_q[IDX_W-1:0]] <= bus.chr_data;
        end
    end

endmodule

// File: tb/tb_packet_parser.sv
// tb/tb_packet_parser.sv - scoreboard bench for packet_parser
module tb_packet_parser;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    logic [15:0] exp_cmd[$];
    logic [8:0]  exp_byte[$];
    logic [2:0]  exp_err[$];

    packet_parser_if bus ();

    packet_parser #(.MAX_LEN(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic s, input logic e, input logic [7:0] d, input int hold);
        @(posedge clk);
        #1;
        bus.chr_drdy  = 1'b1;
        bus.chr_start = s;
        bus.chr_end   = e;
        bus.chr_data  = d;
        repeat (hold) @(posedge clk);
        #1;
        bus.chr_drdy  = 1'b0;
        bus.chr_start = 1'b0;
        bus.chr_end   = 1'b0;
    endtask

    task automatic sstart();
        send(1'b1, 1'b0, 8'h00, 1);
    endtask

    task automatic send_end();
        send(1'b0, 1'b1, 8'h00, 1);
    endtask

    task automatic sdata(input logic [7:0] d);
        send(1'b0, 1'b0, d, 1);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (bus.busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check(name, bus.busy, 0);
    endtask

    // monitor: pops and compares whenever the DUT presents a transfer or error pulse
    initial begin
        logic [15:0] ec;
        logic [8:0]  eb;
        logic [2:0]  ee;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (bus.cmd_valid && bus.cmd_ready) begin
                    if (exp_cmd.size() == 0) check("unexpected_cmd", 1, 0);
                    else begin
                        ec = exp_cmd.pop_front();
                        check("cmd", {bus.cmd_write, bus.cmd_addr, bus.cmd_len}, {16'h0, ec});
                    end
                end
                if (bus.byte_valid && bus.byte_ready) begin
                    if (exp_byte.size() == 0) check("unexpected_byte", 1, 0);
                    else begin
                        eb = exp_byte.pop_front();
                        check("byte", {bus.byte_last, bus.byte_data}, {23'h0, eb});
                    end
                end
                if (bus.frame_err) begin
                    if (exp_err.size() == 0) check("unexpected_frame_err", 1, 0);
                    else begin
                        ee = exp_err.pop_front();
                        check("err_code", bus.err_code, {29'h0, ee});
                    end
                end
            end
        end
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset          = 1'b1;
        bus.chr_drdy   = 1'b0;
        bus.chr_data   = 8'h00;
        bus.chr_start  = 1'b0;
        bus.chr_end    = 1'b0;
        bus.cmd_ready  = 1'b1;
        bus.byte_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_valid", bus.cmd_valid, 0);
        check("rst_byte_valid", bus.byte_valid, 0);
        check("rst_frame_err", bus.frame_err, 0);
        check("rst_err_code", bus.err_code, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_desc", {bus.cmd_write, bus.cmd_addr, bus.cmd_len, bus.byte_data, bus.byte_last}, 0);
        reset = 1'b0;
        repeat (2) @(posedge clk);

`ifdef PACKET_PARSER_CHECKSUM_EN
        // good checksum write: 0x83 ^ 0x0F = 0x8C
        exp_cmd.push_back({1'b1, 7'h03, 8'd1});
        exp_byte.push_back({1'b1, 8'h0F});
        sstart(); sdata(8'h83); sdata(8'h0F); sdata(8'h8C); send_end();
        wait_idle("cs_good_idle");

        exp_err.push_back(3'd7);
        sstart(); sdata(8'h83); sdata(8'h0F); sdata(8'h8D); send_end();
        wait_idle("cs_bad_idle");
        check("cs_bad_code_held", bus.err_code, 7);

        exp_cmd.push_back({1'b0, 7'h05, 8'd0});
        sstart(); sdata(8'h05); sdata(8'h05); send_end();
        wait_idle("cs_read_idle");

        exp_err.push_back(3'd1);
        sstart(); sdata(8'h05); send_end();
        wait_idle("cs_read_nocs_idle");
`else
        // basic write frame
        exp_cmd.push_back({1'b1, 7'h05, 8'd2});
        exp_byte.push_back({1'b0, 8'h11});
        exp_byte.push_back({1'b1, 8'h22});
        sstart(); sdata(8'h85); sdata(8'h11); sdata(8'h22); send_end();
        wait_idle("write_idle");

        // read frame, descriptor held while cmd_ready low
        bus.cmd_ready = 1'b0;
        sstart(); sdata(8'h05); send_end();
        check("read_valid_n1", bus.cmd_valid, 1);
        repeat (3) @(negedge clk);
        check("read_valid_hold", bus.cmd_valid, 1);
        check("read_desc_hold", {bus.cmd_write, bus.cmd_addr, bus.cmd_len}, {1'b0, 7'h05, 8'd0});
        exp_cmd.push_back({1'b0, 7'h05, 8'd0});
        @(posedge clk); #1;
        bus.cmd_ready = 1'b1;
        wait_idle("read_idle");

        // overflow: 17th byte rejected
        exp_err.push_back(3'd2);
        sstart(); sdata(8'h80);
        for (int i = 0; i < 17; i++) sdata(8'(i));
        wait_idle("overflow_idle");

        // resync then a read
        exp_err.push_back(3'd4);
        exp_cmd.push_back({1'b0, 7'h02, 8'd0});
        sstart(); sdata(8'h81); sdata(8'hAA); sstart(); sdata(8'h02); send_end();
        wait_idle("resync_idle");

        // header END, read payload, write empty
        exp_err.push_back(3'd1);
        sstart(); send_end();
        wait_idle("empty_idle");
        exp_err.push_back(3'd3);
        sstart(); sdata(8'h05); sdata(8'h11);
        wait_idle("readpl_idle");
        exp_err.push_back(3'd6);
        sstart(); sdata(8'h85); send_end();
        wait_idle("wempty_idle");
        check("err_code_held", bus.err_code, 6);

        // exactly MAX_LEN bytes; one byte with chr_drdy held for 3 cycles
        exp_cmd.push_back({1'b1, 7'h7F, 8'd16});
        sstart(); sdata(8'hFF);
        for (int i = 0; i < 16; i++) begin
            exp_byte.push_back({(i == 15), 8'(8'hA0 + i)});
            send(1'b0, 1'b0, 8'(8'hA0 + i), (i == 5) ? 3 : 1);
        end
        send_end();
        wait_idle("full_idle");

        // backpressure with an overrun character
        bus.byte_ready = 1'b0;
        exp_cmd.push_back({1'b1, 7'h0A, 8'd2});
        sstart(); sdata(8'h8A); sdata(8'h33); sdata(8'h44); send_end();
        repeat (3) @(negedge clk);
        check("bp_valid", bus.byte_valid, 1);
        check("bp_data", bus.byte_data, 8'h33);
        exp_err.push_back(3'd5);
        sdata(8'h55);
        repeat (2) @(negedge clk);
        check("bp_data_stable", bus.byte_data, 8'h33);
        check("bp_still_stream", bus.byte_valid, 1);
        exp_byte.push_back({1'b0, 8'h33});
        exp_byte.push_back({1'b1, 8'h44});
        @(posedge clk); #1;
        bus.byte_ready = 1'b1;
        wait_idle("bp_idle");
`endif

        // reset mid-frame: no error pulse, everything back to idle
        sstart(); sdata(8'h85); sdata(8'h11);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_busy", bus.busy, 0);
        check("midrst_err_code", bus.err_code, 0);
        check("midrst_frame_err", bus.frame_err, 0);

        repeat (5) @(negedge clk);
        check("cmd_queue_empty", exp_cmd.size(), 0);
        check("byte_queue_empty", exp_byte.size(), 0);
        check("err_queue_empty", exp_err.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/packet_parser.md
# packet_parser

Consumes the decoded character stream from the UART character decoder (data bytes plus start/end markers) and assembles complete Uniboard command frames. A frame is START, header byte, optional payload, END. The header byte is {rw, addr[6:0]}.

- Write payloads are buffered, and nothing is released until END is seen, so aborted or malformed frames never reach the register bank.
- Each accepted frame is presented as one command descriptor, followed by its payload as a ready/valid byte stream, to the peripheral register dispatcher.

## Interface
Parameters:
- MAX_LEN, 16, maximum write payload bytes per frame (1..255).

Ports:
- clk  in  1  system clock (12 MHz).
- reset  in  1  asynchronous, active-high reset.
- chr_drdy  in  1  decoder data-ready; a rising edge marks a new character.
- chr_data  in  8  decoder data byte; valid when chr_drdy rises.
- chr_start  in  1  character is START; chr_data is ignored.
- chr_end  in  1  character is END; chr_data is ignored.
- cmd_valid  out  1  command descriptor valid.
- cmd_ready  in  1  dispatcher accepts the descriptor.
- cmd_write  out  1  1 = write frame, 0 = read frame.
- cmd_addr  out  7  register address.
- cmd_len  out  8  payload byte count (0 for reads).
- byte_valid  out  1  payload byte valid.
- byte_ready  in  1  dispatcher accepts the byte.
- byte_data  out  8  payload byte.
- byte_last  out  1  final payload byte of the frame.
- frame_err  out  1  one-cycle pulse when a frame is dropped.
- err_code  out  3  cause of the most recent error; held until the next error.
- busy  out  1  high in every state except IDLE.

## Operation
- Character event: chr_drdy is high and its registered previous value is low. chr_data, chr_start and chr_end are sampled in that same cycle. The previous-value register resets to 0.
- States: IDLE, HEADER, PAYLOAD, CMD, STREAM.
- IDLE: START → HEADER, with len and idx cleared. All other characters are ignored silently.
- HEADER:
  - Data byte → latch cmd_write = bit7 and cmd_addr = bits[6:0], then go to PAYLOAD.
  - END → error 1 (EMPTY), go to IDLE.
  - START → error 4 (RESYNC), stay in HEADER.
- PAYLOAD:
  - Data byte on a write frame: if len < MAX_LEN, write buf[len] and increment len. Otherwise raise error 2 (OVERFLOW) and go to IDLE.
  - Data byte on a read frame → error 3 (READ_PAYLOAD), go to IDLE.
  - START → error 4, go to HEADER with len cleared.
  - END on a write with len = 0 → error 6 (WRITE_EMPTY), go to IDLE.
  - Any other END → go to CMD.
- CMD: cmd_valid is high. On cmd_valid & cmd_ready: a write goes to STREAM with idx = 0; a read goes to IDLE.
- STREAM:
  - byte_data = buf[idx], byte_valid = 1, byte_last = (idx == len-1).
  - On a handshake, idx increments. After the last byte is accepted, go to IDLE.
- Character events in CMD or STREAM are dropped and raise error 5 (OVERRUN); the state is unchanged.
- Descriptor fields (cmd_*) stay stable from CMD entry until the return to IDLE.
- Error codes: 0 none, 1 EMPTY, 2 OVERFLOW, 3 READ_PAYLOAD, 4 RESYNC, 5 OVERRUN, 6 WRITE_EMPTY, 7 CHECKSUM.

## Timing
- Reset values: all outputs 0, err_code 0, state IDLE, buffer contents undefined.
- A reset asserted mid-frame discards the frame with no frame_err pulse.
- Characters are processed in the cycle of the chr_drdy rising edge, and the resulting state is visible the next cycle.
- END event in cycle N → cmd_valid high in cycle N+1.
- cmd_valid and the cmd_* fields hold until the handshake.
- The first byte_valid comes the cycle after the cmd handshake. Throughput is 1 byte/cycle while byte_ready stays high.
- byte_valid and byte_data hold until the handshake.
- frame_err is high for exactly the cycle after the offending event, and err_code updates in that same cycle.
- A chr_drdy that stays high generates exactly one event.

## Configuration
- PACKET_PARSER_CHECKSUM_EN defined:
  - The final byte before END is a checksum equal to the XOR of the header and all payload bytes.
  - A running XOR over the header, payload and checksum must equal 0 at END. Otherwise raise error 7 (CHECKSUM) and go to IDLE.
  - The checksum byte is excluded from cmd_len and from the stream.
  - The buffer holds MAX_LEN+1 entries.
  - Read frames carry exactly one checksum byte; a second byte raises error 3. A read with no checksum byte, i.e. an END directly after the header, raises error 1.
- Undefined: no checksum byte is expected, error 7 never occurs, and the buffer holds MAX_LEN entries.

## Test plan
- Write frame (checksum disabled): START, 0x85, 0x11, 0x22, END with both readies high → cmd_write=1, cmd_addr=0x05, cmd_len=2; then bytes 0x11 and 0x22, with byte_last on 0x22; frame_err never asserts.
- Read frame: START, 0x05, END → one descriptor with cmd_write=0, cmd_addr=0x05, cmd_len=0; byte_valid never asserts.
- Overflow (MAX_LEN=16): START, 0x80, then 17 data bytes → frame_err pulse with err_code=2, no cmd_valid, busy=0.
- Resync: START, 0x81, 0xAA, START, 0x02, END → err_code=4 pulse, then a read descriptor with cmd_addr=0x02.
- Backpressure and overrun: hold byte_ready=0 in STREAM and send a character → err_code=5; byte_data stays stable; once ready is raised, the full payload is delivered intact.
- Checksum enabled: START, 0x83, 0x0F, 0x8C, END → cmd_len=1, byte 0x0F. The same frame with 0x8D as the final byte → err_code=7 and no descriptor.
